// File: rtl/cdr_pkg.sv
// Shared types and helpers for the oversampling clock-and-data-recovery block.
package cdr_pkg;

  typedef enum logic [1:0] {
    CNT_0 = 2'd0,
    CNT_1 = 2'd1,
    CNT_2 = 2'd2
  } cnt_e;

  typedef enum logic [1:0] {
    EDGE_NONE   = 2'd0,
    EDGE_ONE    = 2'd1,
    EDGE_GLITCH = 2'd2
  } edge_class_e;

  typedef enum logic {
    MODE_ACQ   = 1'b0,
    MODE_TRACK = 1'b1
  } mode_e;

  function automatic int phase_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Difference q - p folded into the half-open range (-n/2, n/2].
  function automatic int wrap_err(input int q, input int p, input int n);
    int d;
    d = q - p;
    if (d > n / 2) d = d - n;
    else if (d <= -(n / 2)) d = d + n;
    return d;
  endfunction

endpackage

// File: rtl/cdr_phase_detector.sv
// Combinational edge finder for one sample window: classifies the edge count,
// locates a single edge and reports the wrapped error against the current phase.
module cdr_phase_detector
  import cdr_pkg::*;
#(
  parameter int N  = 10,
  parameter int PW = phase_w(N)
) (
  input  logic [N-1:0]       win,
  input  logic               prev,
  input  logic [PW-1:0]      phase,
  output edge_class_e        edge_class,
  output logic [PW-1:0]      ideal,
  output logic signed [PW:0] err,
  output logic               err_small,
  output logic               err_far
);

  logic [N-1:0]  edges;
  logic [1:0]    n_edges;
  logic [PW-1:0] e_pos;
  int            q_i;
  int            d_i;

  always_comb begin
    edges   = win ^ {win[N-2:0], prev};
    n_edges = 2'd0;
    e_pos   = '0;
    for (int i = 0; i < N; i++) begin
      if (edges[i]) begin
        e_pos = PW'(i);
        if (n_edges != 2'd2) n_edges = n_edges + 2'd1;
      end
    end

    unique case (n_edges)
      2'd0:    edge_class = EDGE_NONE;
      2'd1:    edge_class = EDGE_ONE;
      default: edge_class = EDGE_GLITCH;
    endcase

    // The eye centre sits half a UI away from the data edge.
    q_i = int'(e_pos) + N / 2;
    if (q_i >= N) q_i = q_i - N;
    ideal = PW'(q_i);

    d_i       = wrap_err(q_i, int'(phase), N);
    err       = (PW + 1)'(d_i);
    err_small = (d_i >= -1) && (d_i <= 1);
    err_far   = (4 * d_i > N) || (4 * d_i < -N);
  end

endmodule

// File: rtl/oversample_cdr.sv
// Oversampled CDR: input register, voting phase filter with acquisition snap,
// slip-aware emission of 0/1/2 bits per window and a lock counter.
module oversample_cdr
  import cdr_pkg::*;
#(
  parameter int NUM_PHASES = 10,
  parameter int FILTER_TH  = 4,
  parameter int LOCK_COUNT = 8
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           sample_valid,
  input  logic [NUM_PHASES-1:0]          samples,
  output logic [1:0]                     data_out,
  output logic [1:0]                     data_count,
  output logic [phase_w(NUM_PHASES)-1:0] phase_sel,
  output logic                           locked
);

  localparam int N  = NUM_PHASES;
  localparam int PW = phase_w(N);
  localparam int VW = $clog2(FILTER_TH + 1) + 1;
  localparam int LW = $clog2(LOCK_COUNT + 1);
  localparam logic [PW-1:0]        PHASE_RST = PW'(N / 2);
  localparam logic [PW-1:0]        PHASE_MAX = PW'(N - 1);
  localparam logic signed [VW-1:0] VOTE_UP   = VW'(FILTER_TH - 1);
  localparam logic signed [VW-1:0] VOTE_DN   = VW'(1 - FILTER_TH);
  localparam logic [LW-1:0]        LOCK_MAX  = LW'(LOCK_COUNT);

  // sample_valid has no backpressure: a window is consumed on every edge where
  // it is high, and a low cycle leaves all loop state untouched.
  logic                   valid_q, valid_d;
  logic [N-1:0]           samples_q, samples_d;
  logic                   prev_q, prev_d;
  logic [PW-1:0]          phase_q, phase_d;
  logic signed [VW-1:0]   vote_q, vote_d;
  logic [LW-1:0]          lock_cnt_q, lock_cnt_d;
  mode_e                  mode_q, mode_d;
  logic                   skip_q, skip_d;
  logic [1:0]             data_q, data_d;
  cnt_e                   count_q, count_d;

  edge_class_e            edge_class;
  logic [PW-1:0]          ideal;
  logic signed [PW:0]     err;
  logic                   err_small, err_far, err_pos, err_neg;
  logic                   inc_wrap, dec_wrap;

  cdr_phase_detector #(.N(N), .PW(PW)) u_pd (
    .win        (samples_q),
    .prev       (prev_q),
    .phase      (phase_q),
    .edge_class (edge_class),
    .ideal      (ideal),
    .err        (err),
    .err_small  (err_small),
    .err_far    (err_far)
  );

  assign err_neg = err[PW];
  assign err_pos = !err[PW] && (err != '0);

  always_comb begin
    valid_d    = sample_valid;
    samples_d  = samples;
    prev_d     = prev_q;
    phase_d    = phase_q;
    vote_d     = vote_q;
    lock_cnt_d = lock_cnt_q;
    mode_d     = mode_q;
    skip_d     = skip_q;
    data_d     = '0;
    count_d    = CNT_0;
    inc_wrap   = 1'b0;
    dec_wrap   = 1'b0;

    if (valid_q) begin
      prev_d = samples_q[N-1];
      skip_d = 1'b0;
      unique case (edge_class)
        EDGE_GLITCH: lock_cnt_d = '0;
        EDGE_ONE: begin
          if (err_small) begin
            if (lock_cnt_q != LOCK_MAX) lock_cnt_d = lock_cnt_q + LW'(1);
          end else if (err_far) begin
            lock_cnt_d = '0;
          end
          if (mode_q == MODE_ACQ) begin
            phase_d = ideal;
            mode_d  = MODE_TRACK;
          end else if (err_pos) begin
            if (vote_q == VOTE_UP) begin
              vote_d = '0;
              if (phase_q == PHASE_MAX) begin
                phase_d  = '0;
                inc_wrap = 1'b1;
              end else begin
                phase_d = phase_q + PW'(1);
              end
            end else begin
              vote_d = vote_q + VW'(1);
            end
          end else if (err_neg) begin
            if (vote_q == VOTE_DN) begin
              vote_d = '0;
              if (phase_q == '0) begin
                phase_d  = PHASE_MAX;
                dec_wrap = 1'b1;
              end else begin
                phase_d = phase_q - PW'(1);
              end
            end else begin
              vote_d = vote_q - VW'(1);
            end
          end
        end
        default: ;
      endcase

      // A pending skip drops the bit at the current phase; it was already
      // emitted as s[N-1] of the window that wrapped forward.
      if (dec_wrap) begin
        data_d  = {samples_q[N-1], samples_q[0]};
        count_d = CNT_2;
      end else begin
        data_d  = {1'b0, samples_q[phase_q]};
        count_d = CNT_1;
      end
      if (skip_q) begin
        if (dec_wrap) begin
          data_d  = {1'b0, samples_q[N-1]};
          count_d = CNT_1;
        end else begin
          data_d  = '0;
          count_d = CNT_0;
        end
      end
      if (inc_wrap) skip_d = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      valid_q    <= 1'b0;
      samples_q  <= '0;
      prev_q     <= 1'b0;
      phase_q    <= PHASE_RST;
      vote_q     <= '0;
      lock_cnt_q <= '0;
      mode_q     <= MODE_ACQ;
      skip_q     <= 1'b0;
      data_q     <= '0;
      count_q    <= CNT_0;
    end else begin
      valid_q    <= valid_d;
      samples_q  <= samples_d;
      prev_q     <= prev_d;
      phase_q    <= phase_d;
      vote_q     <= vote_d;
      lock_cnt_q <= lock_cnt_d;
      mode_q     <= mode_d;
      skip_q     <= skip_d;
      data_q     <= data_d;
      count_q    <= count_d;
    end
  end

  assign data_out   = data_q;
  assign data_count = count_q;
  assign phase_sel  = phase_q;
  assign locked     = (lock_cnt_q == LOCK_MAX);

endmodule

// File: tb/tb_oversample_cdr.sv
// Bench for oversample_cdr: directed window table with hand-derived expectations,
// plus a mid-stream reset sequence.
module tb_oversample_cdr;

  localparam int N     = 10;
  localparam int PW    = 4;
  localparam int EXP_W = 16 + 2 + 2 + PW + 1;

  logic          clock = 1'b0;
  logic          reset;
  logic          sample_valid;
  logic [N-1:0]  samples;
  logic [1:0]    data_out;
  logic [1:0]    data_count;
  logic [PW-1:0] phase_sel;
  logic          locked;

  oversample_cdr #(.NUM_PHASES(N), .FILTER_TH(4), .LOCK_COUNT(8)) dut (
    .clock        (clock),
    .reset        (reset),
    .sample_valid (sample_valid),
    .samples      (samples),
    .data_out     (data_out),
    .data_count   (data_count),
    .phase_sel    (phase_sel),
    .locked       (locked)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic          valid;
    logic [N-1:0]  win;
    logic [1:0]    cnt;
    logic [1:0]    data;
    logic [PW-1:0] phase;
    logic          locked;
  } vec_t;

  vec_t             vecs[$];
  logic [EXP_W-1:0] exp_q[$];
  int               checks   = 0;
  int               failures = 0;
  int               cyc      = 0;
  logic             lvl      = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Window with a single edge at index e, starting from the current line level.
  task automatic add_edge(input int e, input int p, input int cnt, input int ph, input logic lk);
    vec_t v;
    for (int i = 0; i < N; i++) v.win[i] = (i < e) ? lvl : ~lvl;
    v.valid  = 1'b1;
    v.cnt    = cnt[1:0];
    v.data   = (cnt == 2) ? {v.win[N-1], v.win[0]} : {1'b0, v.win[p]};
    v.phase  = ph[PW-1:0];
    v.locked = lk;
    vecs.push_back(v);
    lvl = ~lvl;
  endtask

  task automatic add_raw(input logic vld, input logic [N-1:0] w, input int cnt,
                         input logic [1:0] d, input int ph, input logic lk);
    vec_t v;
    v.valid  = vld;
    v.win    = w;
    v.cnt    = cnt[1:0];
    v.data   = d;
    v.phase  = ph[PW-1:0];
    v.locked = lk;
    vecs.push_back(v);
    if (vld) lvl = w[N-1];
  endtask

  task automatic compare_due();
    logic [EXP_W-1:0] e;
    if (exp_q.size() != 0) begin
      e = exp_q[0];
      if (int'(e[EXP_W-1 -: 16]) + 2 == cyc) begin
        void'(exp_q.pop_front());
        check("data_count", data_count, e[PW+4:PW+3]);
        check("phase_sel", phase_sel, e[PW:1]);
        check("locked", locked, e[0]);
        if (e[PW+4:PW+3] != 2'd0) check("data_out0", data_out[0], e[PW+1]);
        if (e[PW+4:PW+3] == 2'd2) check("data_out1", data_out[1], e[PW+2]);
      end
    end
  endtask

  task automatic step(input logic v, input logic [N-1:0] w, input logic push,
                      input logic [1:0] cnt, input logic [1:0] d,
                      input logic [PW-1:0] ph, input logic lk);
    int stamp;
    @(negedge clock);
    cyc++;
    compare_due();
    sample_valid = v;
    samples      = w;
    stamp        = cyc;
    if (push) exp_q.push_back({stamp[15:0], cnt, d, ph, lk});
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_data_out"}, data_out, 0);
    check({tag, "_data_count"}, data_count, 0);
    check({tag, "_phase_sel"}, phase_sel, N / 2);
    check({tag, "_locked"}, locked, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [N-1:0] junk;
    reset        = 1'b1;
    sample_valid = 1'b0;
    samples      = '0;
    repeat (3) @(negedge clock);
    check_reset_values("rst");
    reset = 1'b0;

    // Acquisition on edge index 2 then lock after eight tracking windows.
    add_edge(2, 5, 1, 7, 1'b0);
    for (int i = 0; i < 8; i++) add_edge(2, 7, 1, 7, i == 7);
    add_edge(2, 7, 1, 7, 1'b1);
    // Edge at 3: four +1 votes move 7 -> 8.
    for (int i = 0; i < 4; i++) add_edge(3, 7, 1, (i == 3) ? 8 : 7, 1'b1);
    for (int i = 0; i < 2; i++) add_edge(3, 8, 1, 8, 1'b1);
    // Edge at 4: 8 -> 9.
    for (int i = 0; i < 4; i++) add_edge(4, 8, 1, (i == 3) ? 9 : 8, 1'b1);
    add_edge(4, 9, 1, 9, 1'b1);
    // Edge at 5: wrap 9 -> 0, then one skipped window.
    for (int i = 0; i < 4; i++) add_edge(5, 9, 1, (i == 3) ? 0 : 9, 1'b1);
    add_edge(5, 0, 0, 0, 1'b1);
    add_edge(5, 0, 1, 0, 1'b1);
    // Edge at 4 from phase 0: err -1, wrap 0 -> 9 emits two bits.
    for (int i = 0; i < 4; i++) add_edge(4, 0, (i == 3) ? 2 : 1, (i == 3) ? 9 : 0, 1'b1);
    for (int i = 0; i < 2; i++) add_edge(4, 9, 1, 9, 1'b1);
    // Three-edge glitch drops lock, phase holds, relock after eight windows.
    junk = '0;
    for (int i = 0; i < N; i++)
      junk[i] = (i < 2 || i == 5 || i == 6) ? lvl : ~lvl;
    add_raw(1'b1, junk, 1, {1'b0, junk[N-1]}, 9, 1'b0);
    for (int i = 0; i < 9; i++) add_edge(4, 9, 1, 9, i >= 7);
    // Invalid windows interleaved: no output bits, no motion.
    for (int i = 0; i < 6; i++) begin
      if (i % 2 == 1) add_raw(1'b0, N'($urandom_range(0, 1023)), 0, 2'b00, 9, 1'b1);
      else add_edge(4, 9, 1, 9, 1'b1);
    end
    // Edge at 7 from phase 9: err +3 is far, lock clears.
    add_edge(7, 9, 1, 9, 1'b0);

    foreach (vecs[k])
      step(vecs[k].valid, vecs[k].win, 1'b1, vecs[k].cnt, vecs[k].data,
           vecs[k].phase, vecs[k].locked);
    for (int i = 0; i < 6 && exp_q.size() > 0; i++)
      step(1'b0, '0, 1'b0, 2'b00, 2'b00, '0, 1'b0);
    check("drain_empty", exp_q.size(), 0);

    // Reset while a valid window sits in the input register.
    @(negedge clock);
    sample_valid = 1'b1;
    samples      = 10'b1111100000;
    @(negedge clock);
    reset        = 1'b1;
    sample_valid = 1'b1;
    samples      = N'($urandom_range(0, 1023));
    @(negedge clock);
    check_reset_values("midrst");
    reset        = 1'b0;
    sample_valid = 1'b1;
    samples      = 10'b1111111100;
    @(negedge clock);
    check("post_rst_count", data_count, 0);
    check("post_rst_phase", phase_sel, 5);
    sample_valid = 1'b0;
    samples      = 10'b1010101010;
    @(negedge clock);
    check("reacq_count", data_count, 1);
    check("reacq_data", data_out[0], 1);
    check("reacq_phase", phase_sel, 7);
    check("reacq_locked", locked, 0);
    sample_valid = 1'b1;
    samples      = 10'b0000000011;
    @(negedge clock);
    check("idle_count", data_count, 0);
    check("idle_phase", phase_sel, 7);
    sample_valid = 1'b0;
    samples      = '0;
    @(negedge clock);
    check("track_count", data_count, 1);
    check("track_data", data_out[0], 0);
    check("track_phase", phase_sel, 7);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
